// File: rtl/dpram_multi_mode_if.sv
// Bundles the two request ports and the read/collision responses of dpram_multi_mode.
// The master side drives requests; the slave side (the RAM) returns read data and coll_err.
interface dpram_multi_mode_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              a_en;
    logic              a_wr;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic              a_rvalid;
    logic              b_en;
    logic              b_wr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] b_rdata;
    logic              b_rvalid;
    logic              coll_err;

    modport master (
        output a_en, a_wr, a_addr, a_wdata, b_en, b_wr, b_addr, b_wdata,
        input  a_rdata, a_rvalid, b_rdata, b_rvalid, coll_err
    );

    modport slave (
        input  a_en, a_wr, a_addr, a_wdata, b_en, b_wr, b_addr, b_wdata,
        output a_rdata, a_rvalid, b_rdata, b_rvalid, coll_err
    );
endinterface

// File: rtl/dpram_multi_mode.sv
// True dual-port read-first RAM with 1- or 2-cycle read latency and a fixed write-collision winner.
// Handshake: a request is taken on every rising edge where en=1 (no backpressure); rvalid pulses for one cycle per read.
module dpram_multi_mode #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int RD_LAT    = 1,
    parameter int COLL_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    dpram_multi_mode_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    generate
        if (!(RD_LAT == 1 || RD_LAT == 2)) begin : g_bad_rd_lat
            $error("dpram_multi_mode: RD_LAT must be 1 or 2");
        end
    endgenerate

    logic [DATA_W-1:0] mem_q      [DEPTH];
    logic [DATA_W-1:0] mem_d      [DEPTH];
    logic [1:0]        s1_v_q, s1_v_d;
    logic [DATA_W-1:0] s1_data_q  [2];
    logic [DATA_W-1:0] s1_data_d  [2];
    logic [1:0]        out_v_q, out_v_d;
    logic [DATA_W-1:0] out_data_q [2];
    logic [DATA_W-1:0] out_data_d [2];
    logic              coll_err_q, coll_err_d;

    logic [1:0]        rd_req;
    logic [1:0]        we_req;
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wdata [2];

    always_comb begin
        rd_req     = {bus.b_en & ~bus.b_wr, bus.a_en & ~bus.a_wr};
        we_req     = {bus.b_en &  bus.b_wr, bus.a_en &  bus.a_wr};
        addr[0]    = bus.a_addr;
        addr[1]    = bus.b_addr;
        wdata[0]   = bus.a_wdata;
        wdata[1]   = bus.b_wdata;
        coll_err_d = we_req[0] & we_req[1] & (addr[0] == addr[1]);

        mem_d = mem_q;
        for (int p = 0; p < 2; p++) begin
            // On a same-address dual write only the COLL_MODE port lands.
            if (we_req[p] && !(coll_err_d && (p != COLL_MODE))) begin
                mem_d[addr[p]] = wdata[p];
            end
        end

        for (int p = 0; p < 2; p++) begin
            s1_v_d[p]    = rd_req[p];
            s1_data_d[p] = rd_req[p] ? mem_q[addr[p]] : s1_data_q[p];
            if (RD_LAT == 1) begin
                out_v_d[p]    = rd_req[p];
                out_data_d[p] = s1_data_d[p];
            end else begin
                out_v_d[p]    = s1_v_q[p];
                out_data_d[p] = s1_v_q[p] ? s1_data_q[p] : out_data_q[p];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int p = 0; p < 2; p++) begin
                s1_data_q[p]  <= '0;
                out_data_q[p] <= '0;
            end
            s1_v_q     <= '0;
            out_v_q    <= '0;
            coll_err_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            s1_v_q     <= s1_v_d;
            s1_data_q  <= s1_data_d;
            out_v_q    <= out_v_d;
            out_data_q <= out_data_d;
            coll_err_q <= coll_err_d;
        end
    end

    assign bus.a_rdata  = out_data_q[0];
    assign bus.b_rdata  = out_data_q[1];
    assign bus.a_rvalid = out_v_q[0];
    assign bus.b_rvalid = out_v_q[1];
    assign bus.coll_err = coll_err_q;
endmodule

// File: tb/tb_dpram_multi_mode.sv
// Drives two RAM instances (RD_LAT=1/port-A wins, RD_LAT=2/port-B wins) with identical traffic
// and checks each against an array model plus per-port expected-read queues.
module tb_dpram_multi_mode;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en_s [2];
  logic       wr_s [2];
  logic [3:0] ad_s [2];
  logic [7:0] wd_s [2];

  dpram_multi_mode_if #(.DATA_W(8), .ADDR_W(4)) if0 ();
  dpram_multi_mode_if #(.DATA_W(8), .ADDR_W(4)) if1 ();

  assign if0.a_en = en_s[0]; assign if0.a_wr = wr_s[0]; assign if0.a_addr = ad_s[0]; assign if0.a_wdata = wd_s[0];
  assign if0.b_en = en_s[1]; assign if0.b_wr = wr_s[1]; assign if0.b_addr = ad_s[1]; assign if0.b_wdata = wd_s[1];
  assign if1.a_en = en_s[0]; assign if1.a_wr = wr_s[0]; assign if1.a_addr = ad_s[0]; assign if1.a_wdata = wd_s[0];
  assign if1.b_en = en_s[1]; assign if1.b_wr = wr_s[1]; assign if1.b_addr = ad_s[1]; assign if1.b_wdata = wd_s[1];

  dpram_multi_mode #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1), .COLL_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  dpram_multi_mode #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2), .COLL_MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // k = 2*dut + port
  logic       rv [4];
  logic [7:0] rd [4];
  logic       ce [2];
  assign rv[0] = if0.a_rvalid; assign rd[0] = if0.a_rdata;
  assign rv[1] = if0.b_rvalid; assign rd[1] = if0.b_rdata;
  assign rv[2] = if1.a_rvalid; assign rd[2] = if1.a_rdata;
  assign rv[3] = if1.b_rvalid; assign rd[3] = if1.b_rdata;
  assign ce[0] = if0.coll_err;
  assign ce[1] = if1.coll_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] mem_m [2][16];
  logic [7:0] exp_q [4][$];
  int         due_q [4][$];
  int         coll_q [2][$];
  logic [7:0] last_exp [4];

  // Reference model: every accepted edge reads old contents, then applies writes.
  // Dut d has RD_LAT=d+1 and collision winner port d.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int d = 0; d < 2; d++) begin
          for (int a = 0; a < 16; a++) mem_m[d][a] = 8'h00;
          coll_q[d].delete();
        end
        for (int k = 0; k < 4; k++) begin
          exp_q[k].delete();
          due_q[k].delete();
        end
      end else begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
          for (int p = 0; p < 2; p++) begin
            if (en_s[p] && !wr_s[p]) begin
              exp_q[2*d+p].push_back(mem_m[d][ad_s[p]]);
              due_q[2*d+p].push_back(cyc + d);
            end
          end
          if (en_s[0] && wr_s[0] && en_s[1] && wr_s[1] && ad_s[0] == ad_s[1]) begin
            mem_m[d][ad_s[0]] = wd_s[d];
            coll_q[d].push_back(cyc);
          end else begin
            for (int p = 0; p < 2; p++)
              if (en_s[p] && wr_s[p]) mem_m[d][ad_s[p]] = wd_s[p];
          end
        end
      end
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard whenever rvalid is seen.
  initial begin
    for (int k = 0; k < 4; k++) last_exp[k] = 8'h00;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (!rst_n) begin
          last_exp[k] = 8'h00;
          checks++;
          if (rv[k] !== 1'b0 || rd[k] !== 8'h00) begin
            errors++;
            $display("FAIL reset_out k=%0d: rvalid=%b rdata=%h, required rvalid=0 rdata=00", k, rv[k], rd[k]);
          end
        end else if (rv[k] === 1'b1) begin
          checks++;
          if (exp_q[k].size() == 0) begin
            errors++;
            $display("FAIL unexpected_rvalid k=%0d cyc=%0d: rdata=%h, required no rvalid", k, cyc, rd[k]);
          end else begin
            int due;
            logic [7:0] ev;
            due = due_q[k].pop_front();
            ev  = exp_q[k].pop_front();
            if (due != cyc || rd[k] !== ev) begin
              errors++;
              $display("FAIL read_data k=%0d: cyc=%0d rdata=%h, required cyc=%0d rdata=%h", k, cyc, rd[k], due, ev);
            end
            last_exp[k] = ev;
          end
        end else begin
          if (due_q[k].size() != 0 && due_q[k][0] <= cyc) begin
            int due;
            logic [7:0] ev;
            due = due_q[k].pop_front();
            ev  = exp_q[k].pop_front();
            checks++;
            errors++;
            $display("FAIL missed_rvalid k=%0d: cyc=%0d rvalid=0, required rvalid=1 rdata=%h at cyc=%0d", k, cyc, ev, due);
          end
          checks++;
          if (rd[k] !== last_exp[k]) begin
            errors++;
            $display("FAIL rdata_hold k=%0d cyc=%0d: rdata=%h, required %h", k, cyc, rd[k], last_exp[k]);
          end
        end
      end
      for (int d = 0; d < 2; d++) begin
        logic exp_c;
        exp_c = rst_n && coll_q[d].size() != 0 && coll_q[d][0] == cyc;
        if (exp_c) void'(coll_q[d].pop_front());
        checks++;
        if (ce[d] !== exp_c) begin
          errors++;
          $display("FAIL coll_err d=%0d cyc=%0d: coll_err=%b, required %b", d, cyc, ce[d], exp_c);
        end
      end
    end
  end

  task automatic op(input logic ae, input logic aw, input logic [3:0] aa, input logic [7:0] ad,
                    input logic be, input logic bw, input logic [3:0] ba, input logic [7:0] bd);
    @(negedge clk);
    en_s[0] = ae; wr_s[0] = aw; ad_s[0] = aa; wd_s[0] = ad;
    en_s[1] = be; wr_s[1] = bw; ad_s[1] = ba; wd_s[1] = bd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      en_s[p] = 1'b0; wr_s[p] = 1'b0; ad_s[p] = 4'h0; wd_s[p] = 8'h00;
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    op(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
    op(1, 1, 4'd7, 8'h5A, 0, 0, 4'd0, 8'h00);
    op(0, 0, 4'd0, 8'h00, 1, 0, 4'd7, 8'h00);
    op(1, 1, 4'd2, 8'h11, 1, 1, 4'd2, 8'h22);
    op(1, 0, 4'd2, 8'h00, 1, 0, 4'd2, 8'h00);
    op(1, 1, 4'd4, 8'h33, 0, 0, 4'd0, 8'h00);
    op(1, 0, 4'd4, 8'h00, 1, 1, 4'd4, 8'h44);
    op(1, 0, 4'd4, 8'h00, 0, 0, 4'd0, 8'h00);
    op(1, 1, 4'd0, 8'hA0, 1, 1, 4'd2, 8'hA2);
    op(1, 1, 4'd1, 8'hA1, 1, 1, 4'd3, 8'hA3);
    for (int i = 0; i < 4; i++) op(1, 0, 4'(i), 8'h00, 0, 0, 4'd0, 8'h00);
    op(0, 0, 4'd0, 8'h00, 1, 1, 4'd15, 8'hF5);
    op(1, 0, 4'd15, 8'h00, 1, 0, 4'd0, 8'h00);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      logic narrow;
      narrow = 1'($urandom_range(0, 1));
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
    idle(3);

    // Reset one cycle after a read: the RD_LAT=2 result is still in flight and must vanish.
    op(1, 0, 4'd5, 8'h00, 1, 0, 4'd7, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b0;
    en_s[0] = 1'b1; wr_s[0] = 1'b1; ad_s[0] = 4'd7; wd_s[0] = 8'hFF;
    en_s[1] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    en_s[0] = 1'b0;
    idle(2);
    op(1, 0, 4'd7, 8'h00, 1, 0, 4'd2, 8'h00);
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
